score_sequencer: RTL and testbench

SCORE_SEQUENCER -- requirements
Module: score_sequencer

---
 rtl/score_sequencer.sv | 169 ++++++++++++++++
 tb/tb_score_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/score_sequencer.sv
// Melody score sequencer: walks a synchronous score ROM and drives note/octave
// to a tone generator with tick-based durations, inter-note gaps, pause and loop.
module score_sequencer #(
    parameter int addr_width  = 6,
    parameter int tick_cycles = 3125000,
    parameter int gap_ticks   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  loop,
    output logic [addr_width-1:0] rom_addr,
    input  logic [11:0]           rom_data,
    output logic [2:0]            octave,
    output logic [3:0]            note,
    output logic                  busy,
    output logic                  done
);
    localparam int tick_w = (tick_cycles > 1) ? $clog2(tick_cycles) : 1;
    localparam int gap_w  = $clog2(gap_ticks + 1);
    localparam int dur_w  = (gap_w > 5) ? gap_w : 5;

    localparam logic [3:0]        rest      = 4'd12;
    localparam logic [tick_w-1:0] tick_last = tick_w'(tick_cycles - 1);
    localparam logic [dur_w-1:0]  gap_load  = dur_w'(gap_ticks);
    localparam logic [dur_w-1:0]  dur_one   = dur_w'(1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

    state_t                state, state_n;
    logic [addr_width-1:0] addr_n;
    logic [2:0]            oct_n;
    logic [3:0]            note_n, note_lat, lat_n;
    logic [tick_w-1:0]     tick_cnt, tick_n;
    logic [dur_w-1:0]      dur_cnt, dur_n;
    logic                  busy_n, done_n;
    logic                  tick_wrap, advance, end_score;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rom_addr <= '0;
            octave   <= '0;
            note     <= rest;
            note_lat <= rest;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            rom_addr <= addr_n;
            octave   <= oct_n;
            note     <= note_n;
            note_lat <= lat_n;
            tick_cnt <= tick_n;
            dur_cnt  <= dur_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = rom_addr;
        oct_n     = octave;
        note_n    = note;
        lat_n     = note_lat;
        tick_n    = tick_cnt;
        dur_n     = dur_cnt;
        done_n    = 1'b0;
        advance   = 1'b0;
        end_score = 1'b0;
        tick_wrap = (tick_cnt == tick_last);

        case (state)
            IDLE: begin
                note_n = rest;
                oct_n  = '0;
                addr_n = '0;
                tick_n = '0;
                dur_n  = '0;
                if (start) state_n = FETCH;
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                if (rom_data[4:0] != 5'd0) begin
                    oct_n   = rom_data[11:9];
                    note_n  = rom_data[8:5];
                    lat_n   = rom_data[8:5];
                    dur_n   = dur_w'(rom_data[4:0]);
                    tick_n  = '0;
                    state_n = PLAY;
                end else if (loop && rom_addr != '0) begin
                    addr_n  = '0;
                    state_n = FETCH;
                end else begin
                    // a zero-length entry at address 0 would otherwise refetch forever
                    end_score = 1'b1;
                end
            end
            PLAY: begin
                if (pause) begin
                    note_n = rest;
                end else begin
                    note_n = note_lat;
                    tick_n = tick_wrap ? '0 : tick_cnt + 1'b1;
                    if (tick_wrap) begin
                        dur_n = dur_cnt - 1'b1;
                        if (dur_cnt == dur_one) begin
                            note_n = rest;
                            if (gap_ticks != 0) begin
                                dur_n   = gap_load;
                                state_n = GAP;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                    end
                end
            end
            GAP: begin
                note_n = rest;
                if (!pause) begin
                    tick_n = tick_wrap ? '0 : tick_cnt + 1'b1;
                    if (tick_wrap) begin
                        dur_n = dur_cnt - 1'b1;
                        if (dur_cnt == dur_one) advance = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // running off the top of the score behaves like an end marker
        if (advance) begin
            if (&rom_addr) begin
                addr_n = '0;
                if (loop) state_n = FETCH;
                else      end_score = 1'b1;
            end else begin
                addr_n  = rom_addr + 1'b1;
                state_n = FETCH;
            end
        end

        if (end_score) begin
            state_n = IDLE;
            done_n  = 1'b1;
            addr_n  = '0;
            note_n  = rest;
            oct_n   = '0;
        end

        if (stop) begin
            state_n = IDLE;
            done_n  = 1'b0;
            addr_n  = '0;
            note_n  = rest;
            oct_n   = '0;
            tick_n  = '0;
            dur_n   = '0;
        end

        busy_n = (state_n != IDLE);
    end
endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer: playback timing, loop, stop, pause,
// end markers, async reset and address wrap on a small score.
module tb_score_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0;
    logic [5:0]  rom_addr;
    logic [11:0] rom_data;
    logic [2:0]  octave;
    logic [3:0]  note;
    logic        busy, done;

    logic        start3 = 1'b0;
    logic [2:0]  rom_addr3;
    logic [11:0] rom_data3;
    logic [2:0]  octave3;
    logic [3:0]  note3;
    logic        busy3, done3;

    logic [11:0] rom  [64];
    logic [11:0] rom3 [8];

    int checks = 0;
    int errors = 0;
    bit sel3 = 1'b0;
    int n_rec = 0;
    int rec_note [256];
    int rec_oct  [256];
    int rec_addr [256];
    int rec_busy [256];
    int rec_done [256];

    always #5 clk = ~clk;
    always @(posedge clk) rom_data  <= rom[rom_addr];
    always @(posedge clk) rom_data3 <= rom3[rom_addr3];

    score_sequencer #(.addr_width(6), .tick_cycles(4), .gap_ticks(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause), .loop(loop),
        .rom_addr(rom_addr), .rom_data(rom_data), .octave(octave), .note(note),
        .busy(busy), .done(done)
    );

    score_sequencer #(.addr_width(3), .tick_cycles(4), .gap_ticks(1)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .stop(stop), .pause(pause), .loop(loop),
        .rom_addr(rom_addr3), .rom_data(rom_data3), .octave(octave3), .note(note3),
        .busy(busy3), .done(done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        n_rec = 0;
    endtask

    // one clock per step, sampled 1 time unit after the rising edge
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (n_rec < 256) begin
                if (sel3) begin
                    rec_note[n_rec] = int'(note3);  rec_oct[n_rec]  = int'(octave3);
                    rec_addr[n_rec] = int'(rom_addr3); rec_busy[n_rec] = int'(busy3);
                    rec_done[n_rec] = int'(done3);
                end else begin
                    rec_note[n_rec] = int'(note);   rec_oct[n_rec]  = int'(octave);
                    rec_addr[n_rec] = int'(rom_addr); rec_busy[n_rec] = int'(busy);
                    rec_done[n_rec] = int'(done);
                end
                n_rec++;
            end
        end
    endtask

    function automatic int cnt_note(input int v);
        int c = 0;
        for (int i = 0; i < n_rec; i++) if (rec_note[i] == v) c++;
        return c;
    endfunction

    function automatic int first_note(input int v);
        for (int i = 0; i < n_rec; i++) if (rec_note[i] == v) return i;
        return -1;
    endfunction

    function automatic int last_note(input int v);
        int l = -1;
        for (int i = 0; i < n_rec; i++) if (rec_note[i] == v) l = i;
        return l;
    endfunction

    function automatic int cnt_done();
        int c = 0;
        for (int i = 0; i < n_rec; i++) c += rec_done[i];
        return c;
    endfunction

    initial begin
        int c;
        for (int i = 0; i < 64; i++) rom[i] = 12'd0;
        rom[0] = {3'd1, 4'd4, 5'd3};   // E oct1, 3 ticks
        rom[1] = {3'd0, 4'd9, 5'd2};   // A oct0, 2 ticks
        for (int i = 0; i < 8; i++) rom3[i] = {3'd2, 4'(i), 5'd1};

        // reset values, forced asynchronously
        #1 reset = 1'b1;
        #2;
        chk("rst_note", 32'(note), 12);
        chk("rst_oct", 32'(octave), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        run(2);

        // single pass: E x12, 6 silent, A x8, one done; a start while busy is ignored
        clear_rec();
        start = 1'b1; run(1); start = 1'b0; run(9);
        start = 1'b1; run(1); start = 1'b0; run(29);
        chk("p1_e_first", first_note(4), 2);
        chk("p1_e_count", cnt_note(4), 12);
        chk("p1_a_count", cnt_note(9), 8);
        chk("p1_gap_len", first_note(9) - last_note(4) - 1, 6);
        chk("p1_e_oct", rec_oct[2], 1);
        chk("p1_a_oct", rec_oct[20], 0);
        chk("p1_fetch1", rec_addr[18], 1);
        chk("p1_done_cnt", cnt_done(), 1);
        chk("p1_done_at", rec_done[34], 1);
        chk("p1_end_busy", rec_busy[39], 0);
        chk("p1_end_addr", rec_addr[39], 0);

        // loop replay, then stop during the second E
        loop = 1'b1;
        clear_rec();
        start = 1'b1; run(1); start = 1'b0; run(39);
        stop = 1'b1; run(1); stop = 1'b0; run(5);
        chk("lp_e2_start", rec_note[36], 4);
        chk("lp_e_count", cnt_note(4), 16);
        chk("lp_stop_note", rec_note[40], 12);
        chk("lp_stop_busy", rec_busy[40], 0);
        chk("lp_stop_addr", rec_addr[40], 0);
        chk("lp_done_cnt", cnt_done(), 0);

        // pause for 10 cycles during E
        loop = 1'b0;
        clear_rec();
        start = 1'b1; run(1); start = 1'b0; run(4);
        pause = 1'b1; run(10); pause = 1'b0; run(40);
        c = 0;
        for (int i = 5; i < 15; i++) if (rec_note[i] == 12) c++;
        chk("ps_silent", c, 10);
        chk("ps_e_count", cnt_note(4), 12);
        chk("ps_e_last", last_note(4), 23);
        chk("ps_a_first", first_note(9), 30);
        chk("ps_done_cnt", cnt_done(), 1);

        // end marker at address 0 with loop set must still terminate
        rom[0] = 12'd0;
        loop = 1'b1;
        clear_rec();
        start = 1'b1; run(1); start = 1'b0; run(7);
        c = 0;
        for (int i = 0; i < n_rec; i++) if (rec_addr[i] != 0) c++;
        chk("z0_done_at", rec_done[2], 1);
        chk("z0_busy", rec_busy[2], 0);
        chk("z0_done_cnt", cnt_done(), 1);
        chk("z0_addr_moves", c, 0);
        rom[0] = {3'd1, 4'd4, 5'd3};
        loop = 1'b0;

        // async reset mid-note, then start+stop together
        clear_rec();
        start = 1'b1; run(1); start = 1'b0; run(5);
        chk("rp_playing", rec_note[5], 4);
        reset = 1'b1;
        #1;
        chk("rp_note", 32'(note), 12);
        chk("rp_oct", 32'(octave), 0);
        chk("rp_busy", 32'(busy), 0);
        chk("rp_addr", 32'(rom_addr), 0);
        #1 reset = 1'b0;
        start = 1'b1; stop = 1'b1; run(2); start = 1'b0; stop = 1'b0;
        chk("ss_busy", 32'(busy), 0);
        chk("ss_note", 32'(note), 12);

        // 8-entry score runs off the top and finishes
        sel3 = 1'b1;
        clear_rec();
        start3 = 1'b1; run(1); start3 = 1'b0; run(89);
        for (int i = 0; i < 8; i++) chk($sformatf("w_note%0d", i), cnt_note(i), 4);
        chk("w_n7_first", first_note(7), 72);
        chk("w_oct", rec_oct[72], 2);
        chk("w_done_at", rec_done[80], 1);
        chk("w_done_cnt", cnt_done(), 1);
        chk("w_addr", rec_addr[80], 0);
        chk("w_busy", rec_busy[89], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
